// File: rtl/athena_audio_pkg.sv
// Shared widths, FSM encoding and output saturation helper for the audio mixer.
package athena_audio_pkg;

    localparam int unsigned AUD_W   = 16;
    localparam int unsigned GAIN_W  = 8;
    localparam int unsigned ACC_W   = 24;
    localparam int unsigned DC_FRAC = 8;
    // DC-blocker output carries one extra integer bit plus the guard fraction bits.
    localparam int unsigned YINT_W  = AUD_W + 1;
    localparam int unsigned Y_W     = YINT_W + DC_FRAC;
    localparam int unsigned PROD_W  = 34;
    localparam int unsigned SUM_W   = PROD_W + 1;

    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(2 ** (AUD_W - 1) - 1);
    localparam logic signed [SUM_W-1:0] SAT_LO = -SUM_W'(2 ** (AUD_W - 1));

    typedef enum logic [2:0] {IDLE, CH1, CH2, SUM, OUT} aud_state_t;

    typedef struct packed {
        logic             clamped;
        logic [AUD_W-1:0] value;
    } sat_t;

    // Clamp a wide signed sum into the 16-bit output range.
    function automatic sat_t sat_aud(input logic signed [SUM_W-1:0] v);
        sat_t r;
        r.clamped = 1'b0;
        r.value   = AUD_W'(v);
        if (v > SAT_HI) begin
            r.clamped = 1'b1;
            r.value   = AUD_W'(SAT_HI);
        end else if (v < SAT_LO) begin
            r.clamped = 1'b1;
            r.value   = AUD_W'(SAT_LO);
        end
        return r;
    endfunction

endpackage

// File: rtl/athena_dc_block.sv
// Single-pole DC blocker step: y = x - x_prev + y_prev - (y_prev >>> DC_K),
// with y kept in fixed point (DC_FRAC guard bits) and saturated to Y_W bits.
module athena_dc_block
    import athena_audio_pkg::*;
#(
    parameter int unsigned DC_K = 8
) (
    input  logic signed [AUD_W-1:0] x,
    input  logic signed [AUD_W-1:0] x_prev,
    input  logic signed [Y_W-1:0]   y_prev,
    output logic signed [Y_W-1:0]   y_next
);

    localparam int unsigned W = Y_W + 2;

    logic signed [ACC_W-1:0] dx;
    logic signed [W-1:0]     acc;

    // Difference, leak and saturation into the stored state width.
    always_comb begin
        dx  = ACC_W'(x) - ACC_W'(x_prev);
        acc = (W'(dx) <<< DC_FRAC) + W'(y_prev) - W'(y_prev >>> DC_K);
        if (!acc[W-1] && (|acc[W-2:Y_W-1])) begin
            y_next = {1'b0, {(Y_W-1){1'b1}}};
        end else if (acc[W-1] && !(&acc[W-2:Y_W-1])) begin
            y_next = {1'b1, {(Y_W-1){1'b0}}};
        end else begin
            y_next = acc[Y_W-1:0];
        end
    end

endmodule

// File: rtl/athena_audio_mixer.sv
// Two-channel mixer: per-channel DC removal and gain, sum, saturate, one output
// sample per strobe. One shared datapath is stepped through CH1/CH2/SUM/OUT.
module athena_audio_mixer
    import athena_audio_pkg::*;
#(
    parameter int unsigned DC_K      = 8,
    parameter int unsigned GAIN_FRAC = 5,
    parameter int unsigned DC_BYPASS = 0
) (
    input  logic                     i_clk,
    input  logic                     RESET,
    input  logic                     pause_cpu,
    input  logic signed [AUD_W-1:0]  snd1,
    input  logic signed [AUD_W-1:0]  snd2,
    input  logic                     sample,
    input  logic        [GAIN_W-1:0] gain1,
    input  logic        [GAIN_W-1:0] gain2,
    input  logic                     mute,
    output logic signed [AUD_W-1:0]  aud_l,
    output logic signed [AUD_W-1:0]  aud_r,
    output logic                     aud_valid,
    output logic                     clip
);

    aud_state_t state, state_next;

    logic                     sample_d;
    logic                     pending;
    logic                     rise_c;
    logic                     start_c;
    logic signed [AUD_W-1:0]  in1, in2;
    logic signed [AUD_W-1:0]  x_prev1, x_prev2;
    logic signed [Y_W-1:0]    y_prev1, y_prev2;
    logic signed [PROD_W-1:0] prod1, prod2;
    logic signed [SUM_W-1:0]  sum_r;

    logic                     sel2_c;
    logic signed [AUD_W-1:0]  dc_x_c, dc_xp_c;
    logic signed [Y_W-1:0]    dc_yp_c, y_next_c;
    logic        [GAIN_W-1:0] gain_c;
    logic signed [YINT_W-1:0] y_int_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [SUM_W-1:0]  sum_c;
    sat_t                     sat_c;

    assign rise_c = sample & ~sample_d & ~pause_cpu;

    athena_dc_block #(.DC_K(DC_K)) u_dc (
        .x      (dc_x_c),
        .x_prev (dc_xp_c),
        .y_prev (dc_yp_c),
        .y_next (y_next_c)
    );

    // Strobe edge detect, sample capture and the single-entry pending flag.
    always_ff @(posedge i_clk or posedge RESET) begin
        if (RESET) begin
            sample_d <= 1'b0;
            pending  <= 1'b0;
            in1      <= '0;
            in2      <= '0;
        end else begin
            sample_d <= sample;
            if (rise_c) begin
                in1 <= snd1;
                in2 <= snd2;
            end
            if (rise_c) begin
                pending <= 1'b1;
            end else if (start_c) begin
                pending <= 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state; a pass starts only from IDLE with a pending sample.
    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_next = CH1;
                    start_c    = 1'b1;
                end
            end
            CH1:     state_next = CH2;
            CH2:     state_next = SUM;
            SUM:     state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shared datapath: channel mux, DC/bypass select, gain multiply, sum and saturation.
    always_comb begin
        sel2_c  = (state == CH2);
        dc_x_c  = sel2_c ? in2 : in1;
        dc_xp_c = sel2_c ? x_prev2 : x_prev1;
        dc_yp_c = sel2_c ? y_prev2 : y_prev1;
        gain_c  = sel2_c ? gain2 : gain1;
        if (DC_BYPASS != 0) begin
            y_int_c = YINT_W'(dc_x_c);
        end else begin
            y_int_c = YINT_W'(y_next_c >>> DC_FRAC);
        end
        prod_c = PROD_W'(y_int_c) * PROD_W'($signed({1'b0, gain_c}));
        sum_c  = (SUM_W'(prod1) + SUM_W'(prod2)) >>> GAIN_FRAC;
        sat_c  = sat_aud(sum_r);
    end

    // Per-channel DC state, products and the scaled sum.
    always_ff @(posedge i_clk or posedge RESET) begin
        if (RESET) begin
            x_prev1 <= '0;
            x_prev2 <= '0;
            y_prev1 <= '0;
            y_prev2 <= '0;
            prod1   <= '0;
            prod2   <= '0;
            sum_r   <= '0;
        end else begin
            case (state)
                CH1: begin
                    prod1   <= prod_c;
                    x_prev1 <= in1;
                    y_prev1 <= y_next_c;
                end
                CH2: begin
                    prod2   <= prod_c;
                    x_prev2 <= in2;
                    y_prev2 <= y_next_c;
                end
                SUM: sum_r <= sum_c;
                default: ;
            endcase
        end
    end

    // Output commit: mute, sticky clip flag and the valid pulse.
    always_ff @(posedge i_clk or posedge RESET) begin
        if (RESET) begin
            aud_l     <= '0;
            aud_r     <= '0;
            aud_valid <= 1'b0;
            clip      <= 1'b0;
        end else begin
            aud_valid <= (state == OUT);
            if (state == OUT) begin
                aud_l <= mute ? '0 : sat_c.value;
                aud_r <= mute ? '0 : sat_c.value;
                if (sat_c.clamped) begin
                    clip <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_athena_audio_mixer.sv
// Bench for athena_audio_mixer: a bypass and a DC-blocking instance share stimulus;
// a transaction-level model predicts every output each cycle, and directed
// literals pin the model at the documented corner cases.
module tb_athena_audio_mixer;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               pause_cpu = 1'b0;
    logic signed [15:0] snd1 = '0;
    logic signed [15:0] snd2 = '0;
    logic               sample = 1'b0;
    logic        [7:0]  gain1 = 8'd32;
    logic        [7:0]  gain2 = 8'd32;
    logic               mute = 1'b0;

    logic signed [15:0] byp_l, byp_r, dc_l, dc_r;
    logic               byp_v, byp_c, dc_v, dc_c;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    athena_audio_mixer #(.DC_K(8), .GAIN_FRAC(5), .DC_BYPASS(1)) dut_byp (
        .i_clk(clk), .RESET(rst), .pause_cpu(pause_cpu), .snd1(snd1), .snd2(snd2),
        .sample(sample), .gain1(gain1), .gain2(gain2), .mute(mute),
        .aud_l(byp_l), .aud_r(byp_r), .aud_valid(byp_v), .clip(byp_c)
    );

    athena_audio_mixer #(.DC_K(8), .GAIN_FRAC(5), .DC_BYPASS(0)) dut_dc (
        .i_clk(clk), .RESET(rst), .pause_cpu(pause_cpu), .snd1(snd1), .snd2(snd2),
        .sample(sample), .gain1(gain1), .gain2(gain2), .mute(mute),
        .aud_l(dc_l), .aud_r(dc_r), .aud_valid(dc_v), .clip(dc_c)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (index 0 = bypass, 1 = DC blocking) -------------
    longint cyc;
    bit     m_sd, m_pend, m_due;
    longint m_pv1, m_pv2, m_pend_edge, m_next_free, m_due_cyc;
    longint m_val [2];
    bit     m_clamp [2];
    longint xp [2][2];
    longint yq [2][2];
    longint e_l [2];
    bit     e_v [2];
    bit     e_clip [2];

    // One channel of one instance: optional DC step in Q8, then gain.
    function automatic longint chan(input int d, input int ch, input longint x, input longint g);
        longint y, yn;
        if (d == 0) begin
            y = x;
        end else begin
            yn = (x - xp[d][ch]) * 256 + yq[d][ch] - (yq[d][ch] >>> 8);
            if (yn > 64'sd16777215) yn = 64'sd16777215;
            if (yn < -64'sd16777216) yn = -64'sd16777216;
            yq[d][ch] = yn;
            y = yn >>> 8;
        end
        xp[d][ch] = x;
        return y * g;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; m_sd = 0; m_pend = 0; m_due = 0;
            m_pv1 = 0; m_pv2 = 0; m_pend_edge = 0; m_next_free = 0; m_due_cyc = 0;
            for (int d = 0; d < 2; d++) begin
                e_l[d] = 0; e_v[d] = 0; e_clip[d] = 0; m_val[d] = 0; m_clamp[d] = 0;
                for (int c = 0; c < 2; c++) begin
                    xp[d][c] = 0; yq[d][c] = 0;
                end
            end
        end else begin
            longint s;
            bit rise;
            cyc++;
            for (int d = 0; d < 2; d++) e_v[d] = 0;
            if (m_due && m_due_cyc == cyc) begin
                for (int d = 0; d < 2; d++) begin
                    e_v[d] = 1;
                    e_l[d] = mute ? 0 : m_val[d];
                    if (m_clamp[d]) e_clip[d] = 1;
                end
                m_due = 0;
            end
            // A pass begins one cycle after capture, no sooner than 5 cycles after the last one.
            if (m_pend && m_pend_edge < cyc && cyc >= m_next_free) begin
                for (int d = 0; d < 2; d++) begin
                    s = (chan(d, 0, m_pv1, longint'(gain1)) + chan(d, 1, m_pv2, longint'(gain2))) >>> 5;
                    m_clamp[d] = (s > 32767) || (s < -32768);
                    m_val[d]   = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
                end
                m_due = 1; m_due_cyc = cyc + 4; m_next_free = cyc + 5; m_pend = 0;
            end
            rise = sample && !m_sd;
            m_sd = sample;
            if (rise && !pause_cpu) begin
                m_pend = 1; m_pv1 = snd1; m_pv2 = snd2; m_pend_edge = cyc;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("byp_valid", byp_v, e_v[0]);
            chk("byp_l", byp_l, e_l[0]);
            chk("byp_r", byp_r, e_l[0]);
            chk("byp_clip", byp_c, e_clip[0]);
            chk("dc_valid", dc_v, e_v[1]);
            chk("dc_l", dc_l, e_l[1]);
            chk("dc_r", dc_r, e_l[1]);
            chk("dc_clip", dc_c, e_clip[1]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic strobe(input logic signed [15:0] a, input logic signed [15:0] b);
        @(negedge clk);
        snd1 = a; snd2 = b; sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
    endtask

    task automatic wait_valid(input bit use_dc, input int max_cyc, output int waited);
        bit seen;
        seen = 0;
        waited = 0;
        while (!seen && waited < max_cyc) begin
            @(negedge clk);
            waited++;
            seen = use_dc ? dc_v : byp_v;
        end
        chk("valid_seen", seen, 1);
    endtask

    task automatic count_valid(input int ncyc, output int pulses);
        pulses = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (byp_v || dc_v) pulses++;
        end
    endtask

    initial begin
        int w, pulses, t1, t2, viol;
        longint v1, v2, prev;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_l", byp_l, 0);
        chk("rst_valid", byp_v, 0);
        chk("rst_clip", byp_c, 0);

        // Unity gain, 1000 + (-300), latency of five cycles from the rising edge
        strobe(16'sd1000, -16'sd300);
        wait_valid(1'b0, 12, w);
        chk("unity_latency", w, 5);
        chk("unity_l", byp_l, 700);
        chk("unity_r", byp_r, 700);
        chk("unity_dc_first", dc_l, 700);

        // Saturation both directions, clip stays set
        gain1 = 8'd64; gain2 = 8'd64;
        strobe(16'sd20000, 16'sd20000);
        wait_valid(1'b0, 12, w);
        chk("sat_pos_l", byp_l, 32767);
        chk("sat_pos_clip", byp_c, 1);
        strobe(-16'sd20000, -16'sd20000);
        wait_valid(1'b0, 12, w);
        chk("sat_neg_l", byp_l, -32768);
        chk("sat_neg_clip", byp_c, 1);

        // Mute still pulses valid but commits zero
        gain1 = 8'd32; gain2 = 8'd32; mute = 1'b1;
        strobe(16'sd5000, 16'sd0);
        wait_valid(1'b0, 12, w);
        chk("mute_l", byp_l, 0);
        mute = 1'b0;

        // Pause: rise ignored, output held
        strobe(16'sd1234, 16'sd0);
        wait_valid(1'b0, 12, w);
        chk("pre_pause_l", byp_l, 1234);
        pause_cpu = 1'b1;
        strobe(16'sd3000, 16'sd0);
        count_valid(10, pulses);
        chk("pause_no_valid", pulses, 0);
        chk("pause_hold", byp_l, 1234);
        pause_cpu = 1'b0;
        count_valid(8, pulses);
        chk("unpause_no_valid", pulses, 0);

        // Collision: rises two cycles apart, newest queued, pulses at +5 and +10
        @(negedge clk);
        snd1 = 16'sd100; snd2 = 16'sd0; sample = 1'b1;
        t1 = -1; t2 = -1; pulses = 0; v1 = 0; v2 = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1) sample = 1'b0;
            if (i == 2) begin snd1 = 16'sd200; sample = 1'b1; end
            if (i == 3) sample = 1'b0;
            if (byp_v) begin
                pulses++;
                if (pulses == 1) begin t1 = i; v1 = byp_l; end
                if (pulses == 2) begin t2 = i; v2 = byp_l; end
            end
        end
        chk("coll_pulses", pulses, 2);
        chk("coll_t1", t1 - 1, 5);
        chk("coll_t2", t2 - 1, 10);
        chk("coll_v1", v1, 100);
        chk("coll_v2", v2, 200);

        // Reset mid-pass: outputs and clip clear, no stray valid afterwards
        strobe(16'sd500, 16'sd0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_l", byp_l, 0);
        chk("midrst_r", byp_r, 0);
        chk("midrst_valid", byp_v, 0);
        chk("midrst_clip", byp_c, 0);
        #1 rst = 1'b0;
        count_valid(8, pulses);
        chk("postrst_no_valid", pulses, 0);

        // DC removal on a constant input
        viol = 0; prev = 0;
        for (int n = 0; n < 2000; n++) begin
            strobe(16'sd4096, 16'sd0);
            wait_valid(1'b1, 12, w);
            if (n == 0) chk("dc_first", dc_l, 4096);
            else if (dc_l > prev) viol++;
            prev = dc_l;
        end
        chk("dc_monotone", viol, 0);
        chk("dc_settled", (dc_l < 16 && dc_l > -16), 1);
        chk("dc_byp_pass", byp_l, 4096);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
